// File: rtl/mem_responder_pkg.sv
// Shared types and sizes for the memory responder: FSM states, latched request, bus widths.
package mem_responder_pkg;
    localparam int ADDR_W          = 8;
    localparam int DATA_W          = 8;
    localparam int INSTR_W         = 24;
    localparam int WAIT_CYCLES_DEF = 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_RESP} state_t;

    typedef struct packed {
        logic              ifetch;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;
endpackage

// File: rtl/mem_responder_if.sv
// Core-to-responder request/response bundle.
interface mem_responder_if;
    import mem_responder_pkg::*;
    logic               req;
    logic               ifetch;
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata;
    logic [INSTR_W-1:0] instr;
    logic               ack;
    logic               busy;

    modport master (output req, ifetch, we, addr, wdata, input rdata, instr, ack, busy);
    modport slave  (input req, ifetch, we, addr, wdata, output rdata, instr, ack, busy);
endinterface

// File: rtl/mem_responder_mem_array.sv
// 256x8 storage: synchronous write, combinational read, contents never reset.
module mem_array
    import mem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;

    assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// Multicycle memory responder: optional wait states, one beat per data access,
// three beats per 24-bit instruction fetch, single-cycle ack.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          RST,
    mem_responder_if.slave bus
);
    localparam state_t     BEAT_ENTRY = (WAIT_CYCLES == 0) ? S_BEAT : S_WAIT;
    localparam logic [3:0] WAIT_LAST  = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_t               state;
    req_t                 lat;
    logic [3:0]           wait_cnt;
    logic [1:0]           beat_cnt;
    logic [DATA_W-1:0]    rdata_q;
    logic [INSTR_W-1:0]   instr_q;
    logic                 ack_q;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_rdata;
    logic                 mem_we;

    // Fetch beats walk forward from the latched address, wrapping at 8 bits.
    assign mem_addr = lat.addr + ADDR_W'(beat_cnt);
    // Decoded from the live state so an async reset in BEAT suppresses the write.
    assign mem_we   = (state == S_BEAT) && lat.we && !lat.ifetch;

    mem_array u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (lat.wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            lat      <= '0;
            wait_cnt <= '0;
            beat_cnt <= '0;
            rdata_q  <= '0;
            instr_q  <= '0;
            ack_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                S_IDLE: if (bus.req) begin
                    lat      <= '{ifetch: bus.ifetch, we: bus.we, addr: bus.addr, wdata: bus.wdata};
                    beat_cnt <= '0;
                    wait_cnt <= '0;
                    state    <= BEAT_ENTRY;
                end
                S_WAIT: if (wait_cnt == WAIT_LAST) begin
                    wait_cnt <= '0;
                    state    <= S_BEAT;
                end else begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
                S_BEAT: if (lat.ifetch) begin
                    case (beat_cnt)
                        2'd0:    instr_q[23:16] <= mem_rdata;
                        2'd1:    instr_q[15:8]  <= mem_rdata;
                        default: instr_q[7:0]   <= mem_rdata;
                    endcase
                    if (beat_cnt == 2'd2) begin
                        state <= S_RESP;
                        ack_q <= 1'b1;
                    end else begin
                        beat_cnt <= beat_cnt + 2'd1;
                        state    <= BEAT_ENTRY;
                    end
                end else begin
                    if (!lat.we) rdata_q <= mem_rdata;
                    state <= S_RESP;
                    ack_q <= 1'b1;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.instr = instr_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = (state != S_IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: u=0 selects the WAIT_CYCLES=1 instance, u=1 the WAIT_CYCLES=0 one.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst1, rst0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_responder_if b1();
    mem_responder_if b0();

    mem_responder #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .RST(rst1), .bus(b1));
    mem_responder #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .RST(rst0), .bus(b0));

    task automatic drive(input bit u, input logic r, f, w, input logic [7:0] a, d);
        if (u) begin
            b0.req = r; b0.ifetch = f; b0.we = w; b0.addr = a; b0.wdata = d;
        end else begin
            b1.req = r; b1.ifetch = f; b1.we = w; b1.addr = a; b1.wdata = d;
        end
    endtask

    task automatic wait_idle(input bit u);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!(u ? b0.busy : b1.busy)) break;
        end
    endtask

    // One transaction; edges counts from the req-sampling edge to the first ack cycle (0 = timeout).
    task automatic op(input bit u, input logic f, w, input logic [7:0] a, d,
                      output int edges, output logic [7:0] rd, output logic [23:0] ins);
        wait_idle(u);
        drive(u, 1'b1, f, w, a, d);
        edges = 0; rd = '0; ins = '0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            if (e == 1) drive(u, 1'b0, f, w, a, d);
            if (u ? b0.ack : b1.ack) begin
                edges = e;
                rd  = u ? b0.rdata : b1.rdata;
                ins = u ? b0.instr : b1.instr;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst0 = 1'b1;
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (b1.ack !== 1'b0)    begin errs++; $display("FAIL reset_ack: got %b want 0", b1.ack); end
        checks++; if (b1.busy !== 1'b0)   begin errs++; $display("FAIL reset_busy: got %b want 0", b1.busy); end
        checks++; if (b1.rdata !== 8'h00) begin errs++; $display("FAIL reset_rdata: got %h want 00", b1.rdata); end
        checks++; if (b1.instr !== 24'h0) begin errs++; $display("FAIL reset_instr: got %h want 000000", b1.instr); end
        checks++; if (b0.busy !== 1'b0)   begin errs++; $display("FAIL reset_busy0: got %b want 0", b0.busy); end
        @(negedge clk);
        rst1 = 1'b0; rst0 = 1'b0;
    endtask

    task automatic test_write_read();
        int n; logic [7:0] rd; logic [23:0] ins;
        op(0, 0, 1, 8'h10, 8'h5A, n, rd, ins);
        checks++; if (n !== 3)      begin errs++; $display("FAIL wr_latency: got %0d want 3", n); end
        checks++; if (rd !== 8'h00) begin errs++; $display("FAIL wr_rdata_kept: got %h want 00", rd); end
        op(0, 0, 0, 8'h10, 8'h00, n, rd, ins);
        checks++; if (n !== 3)      begin errs++; $display("FAIL rd_latency: got %0d want 3", n); end
        checks++; if (rd !== 8'h5A) begin errs++; $display("FAIL rd_data: got %h want 5a", rd); end
    endtask

    task automatic test_fetch();
        int n; logic [7:0] rd; logic [23:0] ins;
        op(0, 0, 1, 8'h20, 8'hC1, n, rd, ins);
        op(0, 0, 1, 8'h21, 8'h04, n, rd, ins);
        op(0, 0, 1, 8'h22, 8'h7F, n, rd, ins);
        op(0, 1, 0, 8'h20, 8'h00, n, rd, ins);
        checks++; if (n !== 7)         begin errs++; $display("FAIL fetch_latency: got %0d want 7", n); end
        checks++; if (ins !== 24'hC1047F) begin errs++; $display("FAIL fetch_instr: got %h want c1047f", ins); end
        @(posedge clk); #1;
        checks++; if (b1.ack !== 1'b0) begin errs++; $display("FAIL fetch_ack_1cyc: got %b want 0", b1.ack); end
        checks++; if (b1.busy !== 1'b0) begin errs++; $display("FAIL fetch_idle_after: got %b want 0", b1.busy); end
    endtask

    task automatic test_wrap();
        int n; logic [7:0] rd; logic [23:0] ins;
        op(0, 0, 1, 8'hFF, 8'hAA, n, rd, ins);
        op(0, 0, 1, 8'h00, 8'hBB, n, rd, ins);
        op(0, 0, 1, 8'h01, 8'hCC, n, rd, ins);
        op(0, 1, 0, 8'hFF, 8'h00, n, rd, ins);
        checks++; if (ins !== 24'hAABBCC) begin errs++; $display("FAIL wrap_instr: got %h want aabbcc", ins); end
        checks++; if (rd !== 8'h5A)       begin errs++; $display("FAIL rdata_hold: got %h want 5a", rd); end
    endtask

    task automatic test_back_to_back();
        int n, a1, a2, pulses; logic [7:0] rd, r1, r2; logic [23:0] ins; logic busy4;
        op(0, 0, 1, 8'h30, 8'h11, n, rd, ins);
        op(0, 0, 1, 8'h31, 8'h22, n, rd, ins);
        wait_idle(0);
        drive(0, 1, 0, 0, 8'h30, 8'h00);
        a1 = 0; a2 = 0; pulses = 0; r1 = '0; r2 = '0; busy4 = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            if (b1.ack) begin
                pulses++;
                if (pulses == 1) begin a1 = e; r1 = b1.rdata; end
                else             begin a2 = e; r2 = b1.rdata; end
            end
            if (e == 4) busy4 = b1.busy;
            if (e == 1) drive(0, 1, 1, 1, 8'h77, 8'hFF);
            if (e == 3) drive(0, 1, 0, 0, 8'h31, 8'h00);
            if (e == 5) drive(0, 1, 1, 0, 8'h99, 8'h00);
            if (e == 7) drive(0, 0, 0, 0, 8'h00, 8'h00);
        end
        checks++; if (a1 !== 3)      begin errs++; $display("FAIL b2b_ack1_edge: got %0d want 3", a1); end
        checks++; if (a2 !== 7)      begin errs++; $display("FAIL b2b_ack2_edge: got %0d want 7", a2); end
        checks++; if (pulses !== 2)  begin errs++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
        checks++; if (r1 !== 8'h11)  begin errs++; $display("FAIL b2b_rdata1: got %h want 11", r1); end
        checks++; if (r2 !== 8'h22)  begin errs++; $display("FAIL b2b_rdata2: got %h want 22", r2); end
        checks++; if (busy4 !== 1'b0) begin errs++; $display("FAIL b2b_idle_gap: got %b want 0", busy4); end
        op(0, 0, 0, 8'h30, 8'h00, n, rd, ins);
        checks++; if (rd !== 8'h11)  begin errs++; $display("FAIL b2b_no_stray_write: got %h want 11", rd); end
    endtask

    task automatic test_reset_mid();
        int n; logic [7:0] rd; logic [23:0] ins;
        wait_idle(0);
        drive(0, 1, 1, 0, 8'h20, 8'h00);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            if (e == 1) drive(0, 0, 0, 0, 8'h00, 8'h00);
        end
        rst1 = 1'b1; #1;
        checks++; if (b1.ack !== 1'b0)    begin errs++; $display("FAIL midrst_ack: got %b want 0", b1.ack); end
        checks++; if (b1.busy !== 1'b0)   begin errs++; $display("FAIL midrst_busy: got %b want 0", b1.busy); end
        checks++; if (b1.instr !== 24'h0) begin errs++; $display("FAIL midrst_instr: got %h want 000000", b1.instr); end
        checks++; if (b1.rdata !== 8'h00) begin errs++; $display("FAIL midrst_rdata: got %h want 00", b1.rdata); end
        @(negedge clk); rst1 = 1'b0;
        // Abort a write while it sits in BEAT, before its write edge.
        wait_idle(0);
        drive(0, 1, 0, 1, 8'h10, 8'hEE);
        @(posedge clk); #1; drive(0, 0, 0, 0, 8'h00, 8'h00);
        @(posedge clk); #1; rst1 = 1'b1;
        @(negedge clk); rst1 = 1'b0;
        op(0, 0, 0, 8'h10, 8'h00, n, rd, ins);
        checks++; if (n !== 3)      begin errs++; $display("FAIL postrst_latency: got %0d want 3", n); end
        checks++; if (rd !== 8'h5A) begin errs++; $display("FAIL postrst_mem: got %h want 5a", rd); end
    endtask

    task automatic test_wait0();
        int n; logic [7:0] rd; logic [23:0] ins;
        op(1, 0, 1, 8'h40, 8'h12, n, rd, ins);
        checks++; if (n !== 2)      begin errs++; $display("FAIL w0_wr_latency: got %0d want 2", n); end
        op(1, 0, 0, 8'h40, 8'h00, n, rd, ins);
        checks++; if (n !== 2)      begin errs++; $display("FAIL w0_rd_latency: got %0d want 2", n); end
        checks++; if (rd !== 8'h12) begin errs++; $display("FAIL w0_rd_data: got %h want 12", rd); end
        op(1, 0, 1, 8'h41, 8'h01, n, rd, ins);
        op(1, 0, 1, 8'h42, 8'h02, n, rd, ins);
        op(1, 0, 1, 8'h43, 8'h03, n, rd, ins);
        op(1, 1, 0, 8'h41, 8'h00, n, rd, ins);
        checks++; if (n !== 4)            begin errs++; $display("FAIL w0_fetch_latency: got %0d want 4", n); end
        checks++; if (ins !== 24'h010203) begin errs++; $display("FAIL w0_fetch_instr: got %h want 010203", ins); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fetch();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_wait0();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
